// File: rtl/banco_registradores_param.sv
// banco_registradores_param
// Parametrised MIPS-style register file: NUM_REGS x LARGURA, two combinational
// read ports, one synchronous write port. After a synchronous reset a clear
// engine zeroes one register per cycle; Pronto rises when the walk is done.
// Optional build macro: REG_ZERO_FIXO_EN hardwires register 0 to zero.
module banco_registradores_param #(
    parameter  int LARGURA  = 32,
    parameter  int NUM_REGS = 32,
    parameter  int BYPASS   = 1,
    localparam int END_BITS = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWrite,
    input  logic [END_BITS-1:0] Numero_Reg1,
    input  logic [END_BITS-1:0] Numero_Reg2,
    input  logic [END_BITS-1:0] Numero_Reg_Escrita,
    input  logic [LARGURA-1:0]  Dado_escrita,
    output logic [LARGURA-1:0]  Valor_Reg1,
    output logic [LARGURA-1:0]  Valor_Reg2,
    output logic                Pronto
);

`ifdef REG_ZERO_FIXO_EN
    localparam bit ZERO_FIXO = 1'b1;
`else
    localparam bit ZERO_FIXO = 1'b0;
`endif

    // One extra bit so NUM_REGS itself fits when it is a power of two.
    localparam logic [END_BITS:0]   NUM_REGS_EXT = (END_BITS+1)'(NUM_REGS);
    localparam logic [END_BITS-1:0] ULTIMO       = END_BITS'(NUM_REGS - 1);

    typedef enum logic {
        LIMPA = 1'b0,
        ATIVO = 1'b1
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [END_BITS-1:0] cont_q, cont_d;
    logic [LARGURA-1:0]  registradores [NUM_REGS];

    logic ativo;
    logic end1_ok, end2_ok, end_esc_ok;
    logic escrita_req;
    logic [LARGURA-1:0] leitura1, leitura2;

    assign ativo = (estado_q == ATIVO);
    assign Pronto = ativo;

    // Addresses at or above NUM_REGS only exist when NUM_REGS is not a power of two.
    assign end1_ok    = ({1'b0, Numero_Reg1}        < NUM_REGS_EXT);
    assign end2_ok    = ({1'b0, Numero_Reg2}        < NUM_REGS_EXT);
    assign end_esc_ok = ({1'b0, Numero_Reg_Escrita} < NUM_REGS_EXT);

    // A legal user write this cycle; drives both the array write and the bypass.
    assign escrita_req = ativo && RegWrite && end_esc_ok &&
                         !(ZERO_FIXO && (Numero_Reg_Escrita == '0));

    // State register and clear counter; reset restarts the walk from index 0.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= LIMPA;
            cont_q   <= '0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
        end
    end

    // Next state: LIMPA walks every index once, then hands over to ATIVO.
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        if (estado_q == LIMPA) begin
            cont_d = cont_q + END_BITS'(1);
            if (cont_q == ULTIMO) begin
                estado_d = ATIVO;
                cont_d   = '0;
            end
        end
    end

    // Storage: the clear engine owns the write port during LIMPA, the user in ATIVO.
    // NOTE: the array has no reset branch; it is zeroed by the clear engine so it
    // maps onto plain storage instead of NUM_REGS*LARGURA resettable flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (estado_q == LIMPA) begin
                registradores[cont_q] <= '0;
            end else if (escrita_req) begin
                registradores[Numero_Reg_Escrita] <= Dado_escrita;
            end
        end
    end

    // Read port 1: zero while clearing, out of range or hardwired zero; else bypass/array.
    always_comb begin
        leitura1 = '0;
        if (ativo && end1_ok && !(ZERO_FIXO && (Numero_Reg1 == '0))) begin
            if ((BYPASS != 0) && escrita_req && (Numero_Reg1 == Numero_Reg_Escrita)) begin
                leitura1 = Dado_escrita;
            end else begin
                leitura1 = registradores[Numero_Reg1];
            end
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        leitura2 = '0;
        if (ativo && end2_ok && !(ZERO_FIXO && (Numero_Reg2 == '0))) begin
            if ((BYPASS != 0) && escrita_req && (Numero_Reg2 == Numero_Reg_Escrita)) begin
                leitura2 = Dado_escrita;
            end else begin
                leitura2 = registradores[Numero_Reg2];
            end
        end
    end

    assign Valor_Reg1 = leitura1;
    assign Valor_Reg2 = leitura2;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Self-checking bench for banco_registradores_param. Three instances share one
// stimulus: A (32 regs, bypass), B (32 regs, no bypass), C (24 regs, bypass).
// Honours REG_ZERO_FIXO_EN when the build defines it.
module tb_banco_registradores_param;

`ifdef REG_ZERO_FIXO_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif
    localparam logic [31:0] V99 = ZF ? 32'h0 : 32'h99;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  n1, n2, nw;
    logic [31:0] dado;
    logic [31:0] a1, a2, b1, b2, c1, c2;
    logic        pa, pb, pc;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    banco_registradores_param #(.LARGURA(32), .NUM_REGS(32), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .RegWrite(reg_write),
        .Numero_Reg1(n1), .Numero_Reg2(n2), .Numero_Reg_Escrita(nw),
        .Dado_escrita(dado), .Valor_Reg1(a1), .Valor_Reg2(a2), .Pronto(pa));

    banco_registradores_param #(.LARGURA(32), .NUM_REGS(32), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .RegWrite(reg_write),
        .Numero_Reg1(n1), .Numero_Reg2(n2), .Numero_Reg_Escrita(nw),
        .Dado_escrita(dado), .Valor_Reg1(b1), .Valor_Reg2(b2), .Pronto(pb));

    banco_registradores_param #(.LARGURA(32), .NUM_REGS(24), .BYPASS(1)) u_c (
        .clk(clk), .reset(reset), .RegWrite(reg_write),
        .Numero_Reg1(n1), .Numero_Reg2(n2), .Numero_Reg_Escrita(nw),
        .Dado_escrita(dado), .Valor_Reg1(c1), .Valor_Reg2(c2), .Pronto(pc));

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] ea1, ea2, eb1, eb2, ec1, ec2;
    } vetor_t;

    vetor_t tab [14];

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        ntests++;
        if (atual !== esperado) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Contents expected after the directed table has been applied.
    function automatic logic [31:0] conteudo(input int dut, input int a);
        case (a)
            0:       return V99;
            5:       return 32'h1;
            7:       return 32'hA5A5A5A5;
            23:      return 32'hCAFEF00D;
            26:      return (dut == 2) ? 32'h0 : 32'h55;
            31:      return (dut == 2) ? 32'h0 : 32'h12345678;
            default: return 32'h0;
        endcase
    endfunction

    // Read every address on both ports; zero_all selects the post-clear image.
    task automatic varre(input string tag, input bit zero_all);
        for (int a = 0; a < 32; a++) begin
            n1 = 5'(a);
            n2 = 5'(31 - a);
            #1;
            check($sformatf("%s A r1[%0d]", tag, a), a1, zero_all ? 32'h0 : conteudo(0, a));
            check($sformatf("%s A r2[%0d]", tag, 31 - a), a2, zero_all ? 32'h0 : conteudo(0, 31 - a));
            check($sformatf("%s B r1[%0d]", tag, a), b1, zero_all ? 32'h0 : conteudo(1, a));
            check($sformatf("%s C r1[%0d]", tag, a), c1, zero_all ? 32'h0 : conteudo(2, a));
        end
        tick();
    endtask

    // Run up to 40 edges after reset release, recording the edge where Pronto rises.
    task automatic espera_pronto(input bit escreve, output int ta, output int tb, output int tc);
        ta = 0; tb = 0; tc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (escreve && i >= 5 && i <= 10) begin
                reg_write = 1'b1; nw = 5'd3; dado = 32'hFF; n1 = 5'd3;
            end else begin
                reg_write = 1'b0;
            end
            if (escreve && i == 6) begin
                #1;
                check("limpa bypass A", a1, 32'h0);
                check("limpa bypass C", c1, 32'h0);
            end
            tick();
            if (pa && ta == 0) ta = i;
            if (pb && tb == 0) tb = i;
            if (pc && tc == 0) tc = i;
        end
        reg_write = 1'b0;
    endtask

    int ta, tb, tc;

    initial begin
        tab[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd31,
                    32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
        tab[1]  = '{1'b1, 5'd31, 32'h12345678, 5'd5,  5'd31,
                    32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        tab[2]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31,
                    32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tab[3]  = '{1'b1, 5'd7,  32'h11,       5'd0,  5'd7,
                    32'h0, 32'h11, 32'h0, 32'h0, 32'h0, 32'h11};
        tab[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd5,
                    32'hA5A5A5A5, 32'hDEADBEEF, 32'h11, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
        tab[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,
                    32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tab[6]  = '{1'b1, 5'd26, 32'h55,       5'd26, 5'd23,
                    32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tab[7]  = '{1'b0, 5'd0,  32'h0,        5'd26, 5'd23,
                    32'h55, 32'h0, 32'h55, 32'h0, 32'h0, 32'h0};
        tab[8]  = '{1'b1, 5'd23, 32'hCAFEF00D, 5'd23, 5'd24,
                    32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
        tab[9]  = '{1'b0, 5'd0,  32'h0,        5'd23, 5'd24,
                    32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0};
        tab[10] = '{1'b1, 5'd0,  32'h99,       5'd7,  5'd0,
                    32'hA5A5A5A5, V99, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, V99};
        tab[11] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,
                    V99, V99, V99, V99, V99, V99};
        tab[12] = '{1'b1, 5'd5,  32'h1,        5'd5,  5'd5,
                    32'h1, 32'h1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h1, 32'h1};
        tab[13] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31,
                    32'h1, 32'h12345678, 32'h1, 32'h12345678, 32'h1, 32'h0};

        reset = 1'b1; reg_write = 1'b0; n1 = '0; n2 = '0; nw = '0; dado = '0;

        // Reset held for two edges.
        tick();
        tick();
        check("reset Pronto A", 32'(pa), 32'h0);
        check("reset Pronto B", 32'(pb), 32'h0);
        check("reset Pronto C", 32'(pc), 32'h0);
        check("reset A r1", a1, 32'h0);
        check("reset C r2", c2, 32'h0);

        // Clear walk with a write attempt to reg 3 in the middle of it.
        reset = 1'b0;
        espera_pronto(1'b1, ta, tb, tc);
        check("clear cycles A", 32'(ta), 32'd32);
        check("clear cycles B", 32'(tb), 32'd32);
        check("clear cycles C", 32'(tc), 32'd24);
        varre("pos-limpa", 1'b1);

        // Directed table: pre-edge values, then the edge commits the write.
        foreach (tab[i]) begin
            reg_write = tab[i].we; nw = tab[i].wa; dado = tab[i].wd;
            n1 = tab[i].r1; n2 = tab[i].r2;
            #1;
            check($sformatf("vec%0d A r1", i), a1, tab[i].ea1);
            check($sformatf("vec%0d A r2", i), a2, tab[i].ea2);
            check($sformatf("vec%0d B r1", i), b1, tab[i].eb1);
            check($sformatf("vec%0d B r2", i), b2, tab[i].eb2);
            check($sformatf("vec%0d C r1", i), c1, tab[i].ec1);
            check($sformatf("vec%0d C r2", i), c2, tab[i].ec2);
            tick();
        end
        reg_write = 1'b0;
        varre("conteudo", 1'b0);

        // Reset from ATIVO, then again mid-clear at counter 10.
        n1 = 5'd31; n2 = 5'd23;
        reset = 1'b1;
        tick();
        check("reset ativo Pronto A", 32'(pa), 32'h0);
        check("reset ativo A r1", a1, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("meio limpa Pronto A", 32'(pa), 32'h0);
        check("meio limpa A r1", a1, 32'h0);
        check("meio limpa A r2", a2, 32'h0);
        check("meio limpa B r1", b1, 32'h0);
        check("meio limpa C r2", c2, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        espera_pronto(1'b0, ta, tb, tc);
        check("reinicio cycles A", 32'(ta), 32'd32);
        check("reinicio cycles B", 32'(tb), 32'd32);
        check("reinicio cycles C", 32'(tc), 32'd24);
        varre("pos-reinicio", 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
